pmod_cls_spi_responder: RTL and testbench
=========================================

Name: pmod_cls_spi_responder

Overview:
- Synthesizable SPI Mode 0 responder that emulates the PMOD CLS display's receive side, for loopback self-test and simulation of the CLS driver.
- Oversamples the SCK, CSN and COPI lines in the system clock domain, assembles bytes MSB-first and parses the CLS ANSI escape subset.
- Maintains a 2x16 character shadow of the display, which the tester reads back and compares against the text it commanded.

Parameters:
parm_sync_stages, 2, flip-flop stages on each SPI input synchronizer (legal range 2..4).
parm_max_arg, 99, saturation value for numeric escape arguments.

Ports:
i_ext_spi_clk_x  in  1  system clock.
i_arst_n  in  1  asynchronous active-low reset.
i_sck  in  1  SPI clock from initiator, asynchronous.
i_csn  in  1  SPI chip select, active-low, asynchronous.
i_copi  in  1  SPI data from initiator, asynchronous.
o_rx_byte  out  8  last complete received byte.
o_rx_valid  out  1  one-cycle strobe; o_rx_byte is new.
o_clear_pulse  out  1  one-cycle strobe when a clear is executed.
o_line1  out  128  row 0 text (t_pmod_cls_ascii_line_16); column 0 is bits [127:120].
o_line2  out  128  row 1 text, same format.
o_cursor_row  out  1  current row.
o_cursor_col  out  4  current column.
o_err_count  out  8  count of discarded malformed sequences; saturates at 255.

Behaviour:
Reset (i_arst_n low, asynchronous):
- Synchronizers set CSN=1 and SCK=0.
- Line buffers all 8'h20; cursor at (0,0).
- o_rx_byte=0, all strobes 0, o_err_count=0, parser in ST_TEXT.

SPI receive:
- Each input passes through parm_sync_stages flip-flops.
- A synchronized SCK rising edge while synchronized CSN=0 shifts COPI into the shift register, MSB first.
- The 3-bit bit counter clears while CSN=1.
- CSN rising mid-byte discards the partial byte and leaves parser state untouched.
- Parser state persists across CSN frames, because command and text arrive in separate transactions.
- Timing requirement: SCK high and SCK low each at least parm_sync_stages+1 clocks.
- On the 8th edge, o_rx_byte loads and o_rx_valid pulses in the cycle after edge detection.
- The parser consumes the byte in that same cycle; buffer and cursor updates are visible one cycle after o_rx_valid.

Parser FSM:
- ST_TEXT:
  - 0x1B goes to ST_ESC.
  - Bytes 0x20..0x7E write at (row,col), then col <= col+1 mod 16, wrapping within the same row.
  - All other bytes are ignored.
- ST_ESC:
  - '[' (0x5B) goes to ST_CSI; arg0=arg1=0, argidx=0, digits_seen=0.
  - Any other byte: err++, return to ST_TEXT.
- ST_CSI:
  - '0'..'9': arg[argidx] <= min(arg*10+digit, parm_max_arg); digits_seen=1.
  - ';': if argidx=0 then argidx=1, else err++ and return to ST_TEXT.
  - 'j' (0x6A): if arg0=0, fill both lines with 0x20, cursor=(0,0), pulse o_clear_pulse; any other arg0 is ignored without error. Return to ST_TEXT.
  - 'H' (0x48): row=min(arg0,1), col=min(arg1,15). Return to ST_TEXT.
  - 0x1B: err++, go to ST_ESC (restart the sequence).
  - Any other byte: err++, return to ST_TEXT.
- Only 2 args are accepted. Missing args default to 0.
- o_err_count holds at 255 once it saturates.
- An undefined state encoding recovers to ST_TEXT.

Simultaneous events:
- A byte completing in the same cycle as CSN rising is still delivered.
- A reset assertion mid-byte or mid-sequence returns every register to its reset value immediately.

Test Plan:
- Clear: reset, send 1B 5B 30 6A -> four o_rx_valid pulses, o_clear_pulse once, both lines all 0x20, cursor (0,0), err 0.
- Cursor and text: send 1B 5B 31 3B 30 30 48 in frame A, then "HELLO WORLD 1234" in frame B -> o_line2 = "HELLO WORLD 1234", o_line1 all 0x20, cursor (1,0) after the 16-char wrap.
- Row and column clamp: send ESC[5;40H then 'X' -> 'X' at row 1 col 15, cursor (1,0); then ESC[0;99H, 'A','B' -> row 0: col 15='A', col 0='B'.
- Malformed sequences: send 1B 41, then 1B 5B 31 3B 32 3B -> err_count=2, buffers unchanged; next printable 'Z' is written at the cursor.
- Partial byte: deassert CSN after 5 SCK edges, then send a full 0x41 -> no o_rx_valid for the fragment, single o_rx_valid with 0x41, 'A' written.
- Async reset: assert i_arst_n low mid-way through ESC[1;0H -> all outputs at reset values in the same cycle; following text lands at (0,0).

Source files
------------

// File: rtl/pmod_cls_spi_responder_if.sv
// SPI bus seen by the PMOD CLS responder: the initiator drives all three lines.
`timescale 1ns/1ps
interface pmod_cls_spi_responder_if;
  logic sck;
  logic csn;
  logic copi;

  modport master (output sck, output csn, output copi);
  modport slave  (input sck, input csn, input copi);
endinterface

// File: rtl/pmod_cls_spi_responder.sv
// SPI Mode 0 responder emulating the PMOD CLS receive side: byte assembly,
// ANSI escape subset parser and a 2x16 character shadow of the display.
`timescale 1ns/1ps
module pmod_cls_spi_responder #(
  parameter int parm_sync_stages = 2,
  parameter int parm_max_arg     = 99
) (
  input  logic                      i_ext_spi_clk_x,
  input  logic                      i_arst_n,
  pmod_cls_spi_responder_if.slave   spi,
  output logic [7:0]                o_rx_byte,
  output logic                      o_rx_valid,
  output logic                      o_clear_pulse,
  output logic [127:0]              o_line1,
  output logic [127:0]              o_line2,
  output logic                      o_cursor_row,
  output logic [3:0]                o_cursor_col,
  output logic [7:0]                o_err_count
);

  typedef enum logic [1:0] {ST_TEXT = 2'd0, ST_ESC = 2'd1, ST_CSI = 2'd2} t_state;

  localparam logic [127:0] BLANK_LINE = {16{8'h20}};

  logic [parm_sync_stages-1:0] r_sck_sync, r_csn_sync, r_copi_sync;
  logic         r_sck_prev, r_csn_prev;
  logic [6:0]   r_shift;
  logic [2:0]   r_bitcnt;
  logic [7:0]   r_rx_byte;
  logic         r_rx_valid;
  logic         r_clear_pulse;
  logic [127:0] r_line1, r_line2;
  logic         r_row;
  logic [3:0]   r_col;
  logic [7:0]   r_err;
  t_state       r_state;
  logic [7:0]   r_arg0, r_arg1;
  logic         r_argidx;

  logic         w_sck, w_csn, w_copi, w_sck_rise;
  t_state       w_state_nxt;
  logic         w_wr_char, w_clear, w_goto, w_err, w_args_rst, w_digit, w_semi;
  logic [7:0]   w_arg_sel, w_arg_new;
  logic [15:0]  w_arg_calc;
  logic [6:0]   w_bitpos;

  assign w_sck  = r_sck_sync[parm_sync_stages-1];
  assign w_csn  = r_csn_sync[parm_sync_stages-1];
  assign w_copi = r_copi_sync[parm_sync_stages-1];
  // CSN low in either sample keeps an edge that coincides with CSN rising
  assign w_sck_rise = w_sck & ~r_sck_prev & ~(w_csn & r_csn_prev);

  always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sck_sync  <= '0;
      r_csn_sync  <= '1;
      r_copi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_csn_prev  <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[parm_sync_stages-2:0], spi.sck};
      r_csn_sync  <= {r_csn_sync[parm_sync_stages-2:0], spi.csn};
      r_copi_sync <= {r_copi_sync[parm_sync_stages-2:0], spi.copi};
      r_sck_prev  <= w_sck;
      r_csn_prev  <= w_csn;
    end
  end

  always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_shift    <= 7'd0;
      r_bitcnt   <= 3'd0;
      r_rx_byte  <= 8'd0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_sck_rise) begin
        r_shift  <= {r_shift[5:0], w_copi};
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          r_rx_byte  <= {r_shift, w_copi};
          r_rx_valid <= 1'b1;
        end
      end else if (w_csn) begin
        r_bitcnt <= 3'd0;
      end
    end
  end

  assign w_arg_sel  = r_argidx ? r_arg1 : r_arg0;
  assign w_arg_calc = 16'(w_arg_sel) * 16'd10 + 16'(r_rx_byte[3:0]);
  assign w_arg_new  = (w_arg_calc > 16'(parm_max_arg)) ? 8'(parm_max_arg) : w_arg_calc[7:0];
  assign w_bitpos   = 7'd127 - {r_col, 3'b000};

  always_comb begin
    w_state_nxt = r_state;
    w_wr_char   = 1'b0;
    w_clear     = 1'b0;
    w_goto      = 1'b0;
    w_err       = 1'b0;
    w_args_rst  = 1'b0;
    w_digit     = 1'b0;
    w_semi      = 1'b0;
    if (r_rx_valid) begin
      case (r_state)
        ST_TEXT: begin
          if (r_rx_byte == 8'h1B) begin
            w_state_nxt = ST_ESC;
          end else if (r_rx_byte >= 8'h20 && r_rx_byte <= 8'h7E) begin
            w_wr_char = 1'b1;
          end else begin
            w_state_nxt = ST_TEXT;
          end
        end
        ST_ESC: begin
          if (r_rx_byte == 8'h5B) begin
            w_state_nxt = ST_CSI;
            w_args_rst  = 1'b1;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_TEXT;
          end
        end
        ST_CSI: begin
          if (r_rx_byte >= 8'h30 && r_rx_byte <= 8'h39) begin
            w_digit = 1'b1;
          end else if (r_rx_byte == 8'h3B) begin
            if (!r_argidx) begin
              w_semi = 1'b1;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_TEXT;
            end
          end else if (r_rx_byte == 8'h6A) begin
            w_clear     = (r_arg0 == 8'd0);
            w_state_nxt = ST_TEXT;
          end else if (r_rx_byte == 8'h48) begin
            w_goto      = 1'b1;
            w_state_nxt = ST_TEXT;
          end else if (r_rx_byte == 8'h1B) begin
            w_err       = 1'b1;
            w_state_nxt = ST_ESC;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_TEXT;
          end
        end
        default: w_state_nxt = ST_TEXT;
      endcase
    end else begin
      case (r_state)
        ST_TEXT, ST_ESC, ST_CSI: w_state_nxt = r_state;
        default:                 w_state_nxt = ST_TEXT;
      endcase
    end
  end

  always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= ST_TEXT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_ext_spi_clk_x or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_line1       <= BLANK_LINE;
      r_line2       <= BLANK_LINE;
      r_row         <= 1'b0;
      r_col         <= 4'd0;
      r_err         <= 8'd0;
      r_arg0        <= 8'd0;
      r_arg1        <= 8'd0;
      r_argidx      <= 1'b0;
      r_clear_pulse <= 1'b0;
    end else begin
      r_clear_pulse <= w_clear;
      if (w_args_rst) begin
        r_arg0   <= 8'd0;
        r_arg1   <= 8'd0;
        r_argidx <= 1'b0;
      end
      if (w_digit && r_argidx)  r_arg1 <= w_arg_new;
      if (w_digit && !r_argidx) r_arg0 <= w_arg_new;
      if (w_semi) r_argidx <= 1'b1;
      if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
      if (w_wr_char) begin
        if (r_row) r_line2[w_bitpos -: 8] <= r_rx_byte;
        else       r_line1[w_bitpos -: 8] <= r_rx_byte;
        r_col <= r_col + 4'd1;
      end
      if (w_clear) begin
        r_line1 <= BLANK_LINE;
        r_line2 <= BLANK_LINE;
        r_row   <= 1'b0;
        r_col   <= 4'd0;
      end
      if (w_goto) begin
        r_row <= (r_arg0 != 8'd0);
        r_col <= (r_arg1 > 8'd15) ? 4'd15 : r_arg1[3:0];
      end
    end
  end

  assign o_rx_byte     = r_rx_byte;
  assign o_rx_valid    = r_rx_valid;
  assign o_clear_pulse = r_clear_pulse;
  assign o_line1       = r_line1;
  assign o_line2       = r_line2;
  assign o_cursor_row  = r_row;
  assign o_cursor_col  = r_col;
  assign o_err_count   = r_err;

endmodule

// File: tb/tb_pmod_cls_spi_responder.sv
// Directed bench for pmod_cls_spi_responder: bytes pushed to a scoreboard as sent,
// popped when o_rx_valid fires; display shadow compared against expected text.
`timescale 1ns/1ps
module tb_pmod_cls_spi_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   o_rx_byte;
  logic         o_rx_valid, o_clear_pulse, o_cursor_row;
  logic [127:0] o_line1, o_line2;
  logic [3:0]   o_cursor_col;
  logic [7:0]   o_err_count;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int n_clear = 0;
  logic [7:0] exp_q[$];

  localparam logic [127:0] BLANK = {16{8'h20}};

  always #5 clk = ~clk;

  pmod_cls_spi_responder_if spi();

  pmod_cls_spi_responder dut (
    .i_ext_spi_clk_x (clk),
    .i_arst_n        (rst_n),
    .spi             (spi),
    .o_rx_byte       (o_rx_byte),
    .o_rx_valid      (o_rx_valid),
    .o_clear_pulse   (o_clear_pulse),
    .o_line1         (o_line1),
    .o_line2         (o_line2),
    .o_cursor_row    (o_cursor_row),
    .o_cursor_col    (o_cursor_col),
    .o_err_count     (o_err_count)
  );

  always @(posedge clk) begin
    if (o_rx_valid)    n_valid <= n_valid + 1;
    if (o_clear_pulse) n_clear <= n_clear + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] put(input logic [127:0] l, input int col, input logic [7:0] c);
    logic [127:0] r;
    r = l;
    r[127-8*col -: 8] = c;
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit got;
    exp_q.push_back(b);
    for (int i = 7; i >= 0; i--) begin
      spi.copi = b[i];
      #40;
      spi.sck = 1'b1;
      if (i == 0) begin
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
          @(negedge clk);
          if (o_rx_valid) got = 1'b1;
        end
        chk("rx_seen", got, 1'b1);
        if (got) begin
          chk("rx_byte", o_rx_byte, exp_q.pop_front());
          @(negedge clk);
        end
      end else begin
        #40;
      end
      spi.sck = 1'b0;
      #40;
    end
  endtask

  task automatic send_frame(input string s);
    spi.csn = 1'b0;
    #40;
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    #40;
    spi.csn = 1'b1;
    #80;
  endtask

  task automatic partial_edges(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi.copi = b[7-i];
      #40;
      spi.sck = 1'b1;
      #40;
      spi.sck = 1'b0;
    end
  endtask

  initial begin : stim
    logic [127:0] l1, l2;
    int v0, c0;

    rst_n    = 1'b0;
    spi.sck  = 1'b0;
    spi.csn  = 1'b1;
    spi.copi = 1'b0;
    #23;
    chk("rst_line1", o_line1, BLANK);
    chk("rst_line2", o_line2, BLANK);
    chk("rst_row", o_cursor_row, 1'b0);
    chk("rst_col", o_cursor_col, 4'd0);
    chk("rst_err", o_err_count, 8'd0);
    chk("rst_rxbyte", o_rx_byte, 8'd0);
    chk("rst_valid", o_rx_valid, 1'b0);
    rst_n = 1'b1;
    #40;

    // Clear command
    v0 = n_valid; c0 = n_clear;
    send_frame("\033[0j");
    chk("clr_valid_cnt", n_valid - v0, 4);
    chk("clr_pulse_cnt", n_clear - c0, 1);
    chk("clr_line1", o_line1, BLANK);
    chk("clr_line2", o_line2, BLANK);
    chk("clr_row", o_cursor_row, 1'b0);
    chk("clr_col", o_cursor_col, 4'd0);
    chk("clr_err", o_err_count, 8'd0);

    // Cursor to row 1 then a full 16-char line that wraps the column
    send_frame("\033[1;00H");
    chk("goto_row", o_cursor_row, 1'b1);
    send_frame("HELLO WORLD 1234");
    l2 = "HELLO WORLD 1234";
    l1 = BLANK;
    chk("hello_line2", o_line2, l2);
    chk("hello_line1", o_line1, l1);
    chk("hello_row", o_cursor_row, 1'b1);
    chk("hello_col", o_cursor_col, 4'd0);

    // Clamped row/column
    send_frame("\033[5;40H");
    chk("clamp_col", o_cursor_col, 4'd15);
    send_frame("X");
    l2 = put(l2, 15, "X");
    chk("clamp_x_line2", o_line2, l2);
    chk("clamp_x_row", o_cursor_row, 1'b1);
    chk("clamp_x_col", o_cursor_col, 4'd0);
    send_frame("\033[0;99H");
    send_frame("AB");
    l1 = put(l1, 15, "A");
    l1 = put(l1, 0, "B");
    chk("clamp_ab_line1", o_line1, l1);
    chk("clamp_ab_line2", o_line2, l2);
    chk("clamp_ab_col", o_cursor_col, 4'd1);

    // Malformed sequences
    send_frame("\033A");
    chk("bad_esc_err", o_err_count, 8'd1);
    send_frame("\033[1;2;");
    chk("bad_arg_err", o_err_count, 8'd2);
    chk("bad_line1", o_line1, l1);
    chk("bad_line2", o_line2, l2);
    send_frame("Z");
    l1 = put(l1, 1, "Z");
    chk("after_bad_line1", o_line1, l1);
    chk("after_bad_col", o_cursor_col, 4'd2);

    // Fragment of 5 edges is discarded
    v0 = n_valid;
    spi.csn = 1'b0;
    #40;
    partial_edges(8'h55, 5);
    #40;
    spi.csn = 1'b1;
    #200;
    chk("frag_no_valid", n_valid - v0, 0);
    send_frame("A");
    chk("frag_then_valid", n_valid - v0, 1);
    l1 = put(l1, 2, "A");
    chk("frag_line1", o_line1, l1);

    // Async reset in the middle of ESC[1;0H
    spi.csn = 1'b0;
    #40;
    send_byte(8'h1B);
    send_byte(8'h5B);
    send_byte(8'h31);
    partial_edges(8'h3B, 4);
    spi.sck = 1'b1;
    #13;
    rst_n = 1'b0;
    #1;
    chk("arst_line1", o_line1, BLANK);
    chk("arst_line2", o_line2, BLANK);
    chk("arst_row", o_cursor_row, 1'b0);
    chk("arst_col", o_cursor_col, 4'd0);
    chk("arst_err", o_err_count, 8'd0);
    chk("arst_rxbyte", o_rx_byte, 8'd0);
    chk("arst_valid", o_rx_valid, 1'b0);
    chk("arst_clear", o_clear_pulse, 1'b0);
    spi.sck = 1'b0;
    spi.csn = 1'b1;
    #20;
    rst_n = 1'b1;
    #80;
    send_frame("Q");
    chk("post_rst_line1", o_line1, put(BLANK, 0, "Q"));
    chk("post_rst_row", o_cursor_row, 1'b0);
    chk("post_rst_col", o_cursor_col, 4'd1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
